// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared opcode constants, writeback state and entry types
package wb_stage_pkg;

    localparam int unsigned WB_XLEN = 32;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } wb_state_t;

    typedef struct packed {
        logic               valid;
        logic               we;
        logic [31:0]        instr;
        logic [WB_XLEN-1:0] data;
    } wb_entry_t;

    function automatic logic writes_rd(input logic [6:0] opcode);
        logic w;
        w = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_OP, OPC_OP_IMM, OPC_LUI,
            OPC_AUIPC, OPC_JAL, OPC_JALR: w = 1'b1;
            default:                      w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/wb_instret_cnt.sv
// rtl/wb_instret_cnt.sv - 64-bit retired-instruction counter with priority clear
module wb_instret_cnt (
    input  logic        clk,
    input  logic        rstn_i,
    input  logic        inc_i,
    input  logic        clr_i,
    output logic [63:0] count_o
);

    logic [63:0] count_q;
    logic [63:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = 64'd0;
        end else if (inc_i) begin
            count_d = count_q + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            count_q <= 64'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: result register, RF write port, forwarding tap, halt-drain FSM
// Optional retired-instruction counter enabled by WB_INSTRET_EN.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int unsigned BITSIZE = 32,
    parameter int unsigned N_REGS  = 32
) (
    input  logic                      clk,
    input  logic                      rstn_i,
    input  logic                      halt_i,
    input  logic                      valid_i,
    output logic                      ack_o,
    input  logic [31:0]               instr_i,
    input  logic [BITSIZE-1:0]        data_i,
    output logic                      rf_we_o,
    output logic [$clog2(N_REGS)-1:0] rf_waddr_o,
    output logic [BITSIZE-1:0]        rf_wdata_o,
    output logic                      fwd_valid_o,
    output logic [4:0]                fwd_rd_o,
    output logic [BITSIZE-1:0]        fwd_data_o,
    output logic                      halted_o
`ifdef WB_INSTRET_EN
    ,
    input  logic                      instret_clr_i,
    output logic [63:0]               instret_o
`endif
);

    localparam int unsigned AW = $clog2(N_REGS);

    wb_entry_t wb_q;
    wb_entry_t wb_d;
    wb_state_t state_q;
    wb_state_t state_d;
    logic      unused_instr_bits;

    assign ack_o = valid_i && (state_q == RUN) && !halt_i;

    // wb_q drains every cycle, so only the valid bit needs clearing when idle.
    always_comb begin
        wb_d       = wb_q;
        wb_d.valid = 1'b0;
        if (ack_o) begin
            wb_d.valid = 1'b1;
            wb_d.we    = writes_rd(instr_i[6:0]) && (instr_i[11:7] != 5'd0);
            wb_d.instr = instr_i;
            wb_d.data  = WB_XLEN'(data_i);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (halt_i)      state_d = DRAIN;
            DRAIN:   if (!wb_q.valid) state_d = HALTED;
            HALTED:  if (!halt_i)     state_d = RUN;
            default:                  state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            wb_q    <= '0;
            state_q <= RUN;
        end else begin
            wb_q    <= wb_d;
            state_q <= state_d;
        end
    end

    assign rf_we_o     = wb_q.valid && wb_q.we;
    assign rf_waddr_o  = AW'(wb_q.instr[11:7]);
    assign rf_wdata_o  = BITSIZE'(wb_q.data);
    assign fwd_valid_o = rf_we_o;
    assign fwd_rd_o    = wb_q.instr[11:7];
    assign fwd_data_o  = rf_wdata_o;
    assign halted_o    = (state_q == HALTED);

    assign unused_instr_bits = ^{wb_q.instr[31:12], wb_q.instr[6:0]};

`ifdef WB_INSTRET_EN
    wb_instret_cnt u_instret_cnt (
        .clk     (clk),
        .rstn_i  (rstn_i),
        .inc_i   (wb_q.valid),
        .clr_i   (instret_clr_i),
        .count_o (instret_o)
    );
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - table-driven bench for wb_stage
module tb_wb_stage;
    import wb_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        halt_i;
    logic        valid_i;
    logic        ack_o;
    logic [31:0] instr_i;
    logic [31:0] data_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        fwd_valid_o;
    logic [4:0]  fwd_rd_o;
    logic [31:0] fwd_data_o;
    logic        halted_o;
`ifdef WB_INSTRET_EN
    logic        instret_clr_i;
    logic [63:0] instret_o;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_stage #(.BITSIZE(32), .N_REGS(32)) dut (
        .clk         (clk),
        .rstn_i      (rstn_i),
        .halt_i      (halt_i),
        .valid_i     (valid_i),
        .ack_o       (ack_o),
        .instr_i     (instr_i),
        .data_i      (data_i),
        .rf_we_o     (rf_we_o),
        .rf_waddr_o  (rf_waddr_o),
        .rf_wdata_o  (rf_wdata_o),
        .fwd_valid_o (fwd_valid_o),
        .fwd_rd_o    (fwd_rd_o),
        .fwd_data_o  (fwd_data_o),
        .halted_o    (halted_o)
`ifdef WB_INSTRET_EN
        ,
        .instret_clr_i (instret_clr_i),
        .instret_o     (instret_o)
`endif
    );

    typedef struct {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] data;
        logic        exp_ack;
        logic        exp_we;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[18];

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd);
        return {20'h0, rd, op};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // rf_* columns show the entry accepted on the previous row
        vecs[0]  = '{1'b1, mk(OPC_OP_IMM, 5'd5),   32'h0000_002A, 1'b1, 1'b0, 5'd0,  32'h0};
        vecs[1]  = '{1'b1, mk(OPC_STORE, 5'd3),    32'h0000_0000, 1'b1, 1'b1, 5'd5,  32'h0000_002A};
        vecs[2]  = '{1'b1, mk(OPC_OP_IMM, 5'd0),   32'h0000_1234, 1'b1, 1'b0, 5'd0,  32'h0};
        vecs[3]  = '{1'b1, mk(OPC_LOAD, 5'd1),     32'h0000_0010, 1'b1, 1'b0, 5'd0,  32'h0};
        vecs[4]  = '{1'b1, mk(OPC_LOAD, 5'd2),     32'h0000_0011, 1'b1, 1'b1, 5'd1,  32'h0000_0010};
        vecs[5]  = '{1'b1, mk(OPC_LOAD, 5'd3),     32'h0000_0012, 1'b1, 1'b1, 5'd2,  32'h0000_0011};
        vecs[6]  = '{1'b1, mk(OPC_LOAD, 5'd4),     32'h0000_0013, 1'b1, 1'b1, 5'd3,  32'h0000_0012};
        vecs[7]  = '{1'b0, mk(OPC_LOAD, 5'd9),     32'h0000_0099, 1'b0, 1'b1, 5'd4,  32'h0000_0013};
        vecs[8]  = '{1'b0, mk(OPC_LOAD, 5'd9),     32'h0000_0099, 1'b0, 1'b0, 5'd0,  32'h0};
        vecs[9]  = '{1'b1, mk(OPC_LUI, 5'd7),      32'hDEAD_0000, 1'b1, 1'b0, 5'd0,  32'h0};
        vecs[10] = '{1'b1, mk(OPC_BRANCH, 5'd8),   32'h0000_0001, 1'b1, 1'b1, 5'd7,  32'hDEAD_0000};
        vecs[11] = '{1'b1, mk(OPC_JALR, 5'd9),     32'h0000_0200, 1'b1, 1'b0, 5'd0,  32'h0};
        vecs[12] = '{1'b1, mk(OPC_SYSTEM, 5'd10),  32'h0000_0003, 1'b1, 1'b1, 5'd9,  32'h0000_0200};
        vecs[13] = '{1'b1, mk(OPC_AUIPC, 5'd31),   32'hFFFF_FFFF, 1'b1, 1'b0, 5'd0,  32'h0};
        vecs[14] = '{1'b1, mk(OPC_OP, 5'd2),       32'h0000_0055, 1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF};
        vecs[15] = '{1'b1, mk(OPC_MISC_MEM, 5'd5), 32'h0000_0004, 1'b1, 1'b1, 5'd2,  32'h0000_0055};
        vecs[16] = '{1'b1, mk(7'b1111111, 5'd6),   32'h0000_0005, 1'b1, 1'b0, 5'd0,  32'h0};
        vecs[17] = '{1'b1, mk(OPC_JAL, 5'd1),      32'h0000_0104, 1'b1, 1'b0, 5'd0,  32'h0};

        rstn_i = 1'b0; halt_i = 1'b0; valid_i = 1'b0; instr_i = '0; data_i = '0;
`ifdef WB_INSTRET_EN
        instret_clr_i = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1;
        chk("reset_rf_we", rf_we_o, 0);
        chk("reset_rf_waddr", rf_waddr_o, 0);
        chk("reset_rf_wdata", rf_wdata_o, 0);
        chk("reset_fwd_valid", fwd_valid_o, 0);
        chk("reset_fwd_rd", fwd_rd_o, 0);
        chk("reset_fwd_data", fwd_data_o, 0);
        chk("reset_halted", halted_o, 0);
        chk("reset_ack", ack_o, 0);
        @(negedge clk);
        rstn_i = 1'b1;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            valid_i = vecs[i].valid;
            instr_i = vecs[i].instr;
            data_i  = vecs[i].data;
            #1;
            chk($sformatf("v%0d_ack", i), ack_o, vecs[i].exp_ack);
            chk($sformatf("v%0d_rf_we", i), rf_we_o, vecs[i].exp_we);
            chk($sformatf("v%0d_fwd_valid", i), fwd_valid_o, vecs[i].exp_we);
            chk($sformatf("v%0d_halted", i), halted_o, 0);
            if (vecs[i].exp_we) begin
                chk($sformatf("v%0d_waddr", i), rf_waddr_o, vecs[i].exp_rd);
                chk($sformatf("v%0d_wdata", i), rf_wdata_o, vecs[i].exp_data);
                chk($sformatf("v%0d_fwd_rd", i), fwd_rd_o, vecs[i].exp_rd);
                chk($sformatf("v%0d_fwd_data", i), fwd_data_o, vecs[i].exp_data);
            end
        end

        // halt while JAL x1 is being presented
        @(negedge clk);
        valid_i = 1'b1; instr_i = mk(OPC_OP, 5'd3); data_i = 32'h77; halt_i = 1'b1;
        #1;
        chk("halt_ack", ack_o, 0);
        chk("halt_jal_we", rf_we_o, 1);
        chk("halt_jal_waddr", rf_waddr_o, 1);
        chk("halt_jal_wdata", rf_wdata_o, 32'h104);
        chk("halt_not_yet", halted_o, 0);
        @(negedge clk); #1;
        chk("drain_we", rf_we_o, 0);
        chk("drain_halted", halted_o, 0);
        chk("drain_ack", ack_o, 0);
        @(negedge clk); #1;
        chk("halted_set", halted_o, 1);
        halt_i = 1'b0;
        #1;
        chk("halted_no_ack", ack_o, 0);
        @(negedge clk); #1;
        chk("resume_halted", halted_o, 0);
        chk("resume_ack", ack_o, 1);
        @(negedge clk);
        valid_i = 1'b0;
        #1;
        chk("resume_we", rf_we_o, 1);
        chk("resume_waddr", rf_waddr_o, 3);
        chk("resume_wdata", rf_wdata_o, 32'h77);

        // async reset while halted
        @(negedge clk);
        halt_i = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("pre_rst_halted", halted_o, 1);
        #2 rstn_i = 1'b0;
        #1;
        chk("rst_halted_drop", halted_o, 0);
        @(negedge clk);
        rstn_i = 1'b1; halt_i = 1'b0;

        // async reset while a write is presented
        @(negedge clk);
        valid_i = 1'b1; instr_i = mk(OPC_LOAD, 5'd6); data_i = 32'hABCD;
        #1;
        chk("post_rst_ack", ack_o, 1);
        @(negedge clk);
        valid_i = 1'b0;
        #1;
        chk("pre_rst_we", rf_we_o, 1);
        #2 rstn_i = 1'b0;
        #1;
        chk("rst_we_drop", rf_we_o, 0);
        chk("rst_fwd_drop", fwd_valid_o, 0);
        chk("rst_wdata_zero", rf_wdata_o, 0);
        @(negedge clk);
        rstn_i = 1'b1;
        #1;
        chk("rel_we", rf_we_o, 0);
        @(negedge clk); #1;
        chk("no_stale_we", rf_we_o, 0);
        chk("rel_halted", halted_o, 0);
        valid_i = 1'b1; instr_i = mk(OPC_OP_IMM, 5'd8); data_i = 32'h5;
        #1;
        chk("rel_ack", ack_o, 1);
        @(negedge clk);
        valid_i = 1'b0;
        #1;
        chk("rel_write_we", rf_we_o, 1);
        chk("rel_write_waddr", rf_waddr_o, 8);

`ifdef WB_INSTRET_EN
        @(negedge clk);
        rstn_i = 1'b0;
        @(negedge clk);
        rstn_i = 1'b1;
        #1;
        chk("instret_reset", instret_o, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            valid_i = 1'b1;
            case (i)
                0: instr_i = mk(OPC_OP_IMM, 5'd1);
                1: instr_i = mk(OPC_STORE, 5'd2);
                2: instr_i = mk(OPC_BRANCH, 5'd3);
                3: instr_i = mk(OPC_LOAD, 5'd0);
                default: instr_i = mk(OPC_JAL, 5'd4);
            endcase
        end
        @(negedge clk);
        valid_i = 1'b0;
        @(negedge clk); #1;
        chk("instret_five", instret_o, 5);
        valid_i = 1'b1; instr_i = mk(OPC_OP, 5'd5);
        @(negedge clk);
        valid_i = 1'b0; instret_clr_i = 1'b1;
        @(negedge clk);
        instret_clr_i = 1'b0;
        #1;
        chk("instret_clr", instret_o, 0);
        force dut.u_instret_cnt.count_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.u_instret_cnt.count_q;
        @(negedge clk);
        valid_i = 1'b1; instr_i = mk(OPC_SYSTEM, 5'd0);
        @(negedge clk);
        valid_i = 1'b0;
        @(negedge clk); #1;
        chk("instret_wrap", instret_o, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
